// File: rtl/sparc_ram_loader.sv
// Boot-time preload engine: streams bytes into consecutive SPARC RAM addresses
// over the MOV/MOC handshake while holding the CPU in clear.
module sparc_ram_loader #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int START_ADDR  = 0,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_mov,
    output logic              ram_rw,
    output logic [1:0]        ram_type,
    input  logic              ram_moc,
    output logic              cpu_clr,
    output logic              done,
    output logic              overflow,
    output logic              timeout,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum
);

    localparam int                TMO_W     = $clog2(MOC_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] W_START   = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] W_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0]  W_TMO_LIM = TMO_W'(MOC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_mov;
    logic              r_cpu_clr;
    logic              r_done;
    logic              r_overflow;
    logic              r_timeout;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_csum;
    logic              r_last;
    logic [TMO_W-1:0]  r_tmo;

    function automatic logic [7:0] f_csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    // Loader FSM; every output is a register updated here.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_addr     <= W_START;
            r_data     <= 8'h00;
            r_mov      <= 1'b0;
            r_cpu_clr  <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_count    <= '0;
            r_csum     <= 8'h00;
            r_last     <= 1'b0;
            r_tmo      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= WAIT_BYTE;
                        r_in_ready <= 1'b1;
                        r_addr     <= W_START;
                        r_cpu_clr  <= 1'b1;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_count    <= '0;
                        r_csum     <= 8'h00;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= WRITE;
                        r_in_ready <= 1'b0;
                        r_data     <= in_data;
                        r_last     <= in_last;
                        r_mov      <= 1'b1;
                        r_tmo      <= '0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    if (ram_moc) begin
                        r_mov   <= 1'b0;
                        r_count <= r_count + 1'b1;
                        r_csum  <= f_csum_add(r_csum, r_data);
                        if (r_last) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_cpu_clr <= 1'b0;
                        end else if (r_addr == W_LAST) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_state    <= WAIT_BYTE;
                            r_addr     <= r_addr + 1'b1;
                            r_in_ready <= 1'b1;
                        end
                    end else if (r_tmo == W_TMO_LIM) begin
                        // abandon the byte: no count/checksum update
                        r_state   <= DONE;
                        r_mov     <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_mov      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign ram_addr   = r_addr;
    assign ram_data   = r_data;
    assign ram_mov    = r_mov;
    assign ram_rw     = 1'b0;
    assign ram_type   = 2'b00;
    assign cpu_clr    = r_cpu_clr;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign timeout    = r_timeout;
    assign byte_count = r_count;
    assign checksum   = r_csum;

endmodule

// File: tb/tb_sparc_ram_loader.sv
// Directed bench for sparc_ram_loader with a behavioural RAM that answers
// MOV with MOC after a programmable delay (or never).
module tb_sparc_ram_loader;

    logic       Clk = 1'b0;
    logic       Clr = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [8:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_mov;
    logic       ram_rw;
    logic [1:0] ram_type;
    logic       ram_moc = 1'b0;
    logic       cpu_clr;
    logic       done;
    logic       overflow;
    logic       timeout;
    logic [9:0] byte_count;
    logic [7:0] checksum;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [512];
    int         wr_cnt [512];
    int         moc_delay = 0;
    bit         moc_en = 1'b1;
    int         wcnt = 0;
    int         stab_viol = 0;
    int         rdy_viol = 0;
    logic       prev_mov = 1'b0;
    logic [8:0] prev_addr = 9'd0;
    logic [7:0] prev_data = 8'd0;

    sparc_ram_loader dut (
        .Clk(Clk), .Clr(Clr), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_mov(ram_mov),
        .ram_rw(ram_rw), .ram_type(ram_type), .ram_moc(ram_moc),
        .cpu_clr(cpu_clr), .done(done), .overflow(overflow),
        .timeout(timeout), .byte_count(byte_count), .checksum(checksum)
    );

    always #5 Clk = ~Clk;

    // RAM model: write and raise MOC once the programmed wait has elapsed
    always @(posedge Clk) begin
        if (!ram_mov || ram_moc) begin
            ram_moc <= 1'b0;
            wcnt    <= 0;
        end else if (moc_en) begin
            if (wcnt >= moc_delay) begin
                ram_moc           <= 1'b1;
                mem[ram_addr]     <= ram_data;
                wr_cnt[ram_addr]  <= wr_cnt[ram_addr] + 1;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // Protocol monitor: address/data stable under MOV, no ready during a write
    always @(posedge Clk) begin
        if (prev_mov && ram_mov && (ram_addr !== prev_addr || ram_data !== prev_data))
            stab_viol <= stab_viol + 1;
        if (ram_mov && in_ready)
            rdy_viol <= rdy_viol + 1;
        prev_mov  <= ram_mov;
        prev_addr <= ram_addr;
        prev_data <= ram_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap,
                             input int bound, output bit ok);
        in_valid = 1'b0;
        repeat (gap) @(negedge Clk);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        if (ok) @(negedge Clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        for (c = 0; c < 100 && !done; c++) @(negedge Clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic clear_wr();
        for (int i = 0; i < 512; i++) wr_cnt[i] = 0;
    endtask

    initial begin
        bit ok;
        int nfail;
        int n;
        logic [7:0] sum;
        logic [7:0] d;

        for (int i = 0; i < 512; i++) begin
            mem[i] = 8'h00;
            wr_cnt[i] = 0;
        end

        // Reset state
        #12;
        check("rst_cpu_clr", {31'd0, cpu_clr}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mov", {31'd0, ram_mov}, 32'd0);
        check("rst_count", {22'd0, byte_count}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rw_type", {29'd0, ram_rw, ram_type}, 32'd0);
        @(negedge Clk);
        Clr = 1'b1;

        // 1: four bytes into zero-wait RAM
        pulse_start();
        check("t1_ready", {31'd0, in_ready}, 32'd1);
        nfail = 0;
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), (i == 4), 0, 20, ok);
            if (!ok) nfail++;
        end
        check("t1_accept", nfail, 0);
        wait_done("t1");
        for (int i = 0; i < 4; i++) check("t1_mem", {24'd0, mem[i]}, i + 1);
        check("t1_count", {22'd0, byte_count}, 32'd4);
        check("t1_csum", {24'd0, checksum}, 32'h0A);
        check("t1_cpu_clr", {31'd0, cpu_clr}, 32'd0);
        check("t1_flags", {30'd0, overflow, timeout}, 32'd0);

        // 2: 513 bytes without last -> overflow after 512
        clear_wr();
        pulse_start();
        nfail = 0;
        sum = 8'h00;
        for (int i = 0; i < 512; i++) begin
            d = 8'(i * 7 + 3);
            sum = sum + d;
            send_byte(d, 1'b0, 0, 20, ok);
            if (!ok) nfail++;
        end
        check("t2_accept", nfail, 0);
        wait_done("t2");
        send_byte(8'hEE, 1'b0, 0, 10, ok);
        check("t2_513_refused", {31'd0, ok}, 32'd0);
        check("t2_overflow", {31'd0, overflow}, 32'd1);
        check("t2_cpu_clr", {31'd0, cpu_clr}, 32'd1);
        check("t2_count", {22'd0, byte_count}, 32'd512);
        check("t2_csum", {24'd0, checksum}, {24'd0, sum});
        check("t2_addr", {23'd0, ram_addr}, 32'd511);
        nfail = 0;
        for (int i = 0; i < 512; i++)
            if (wr_cnt[i] != 1 || mem[i] !== 8'(i * 7 + 3)) nfail++;
        check("t2_mem", nfail, 0);

        // 3: MOC never arrives -> timeout after 15 MOV cycles
        moc_en = 1'b0;
        pulse_start();
        send_byte(8'h55, 1'b1, 0, 20, ok);
        n = 0;
        while (ram_mov && n < 40) begin
            n++;
            @(negedge Clk);
        end
        check("t3_mov_cycles", n, 15);
        check("t3_timeout", {31'd0, timeout}, 32'd1);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_count", {22'd0, byte_count}, 32'd0);
        check("t3_cpu_clr", {31'd0, cpu_clr}, 32'd1);
        moc_en = 1'b1;

        // 4: slow RAM, gappy stream
        moc_delay = 3;
        clear_wr();
        @(negedge Clk);
        stab_viol = 0;
        rdy_viol = 0;
        pulse_start();
        nfail = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h30 + 8'(i), (i == 5), i % 3, 40, ok);
            if (!ok) nfail++;
        end
        check("t4_accept", nfail, 0);
        wait_done("t4");
        nfail = 0;
        for (int i = 0; i < 6; i++)
            if (wr_cnt[i] != 1 || mem[i] !== 8'h30 + 8'(i)) nfail++;
        check("t4_mem_once", nfail, 0);
        check("t4_count", {22'd0, byte_count}, 32'd6);
        check("t4_csum", {24'd0, checksum}, 32'h2F);
        check("t4_stable", stab_viol, 0);
        check("t4_ready_low", rdy_viol, 0);
        moc_delay = 0;

        // 5: asynchronous reset mid-write, then reload from address 0
        pulse_start();
        send_byte(8'hA1, 1'b0, 0, 20, ok);
        send_byte(8'hA2, 1'b0, 0, 20, ok);
        send_byte(8'hA3, 1'b0, 0, 20, ok);
        check("t5_mov_before", {31'd0, ram_mov}, 32'd1);
        #1;
        Clr = 1'b0;
        #1;
        check("t5_mov", {31'd0, ram_mov}, 32'd0);
        check("t5_addr", {23'd0, ram_addr}, 32'd0);
        check("t5_data", {24'd0, ram_data}, 32'd0);
        check("t5_count_csum", {14'd0, byte_count, checksum}, 32'd0);
        check("t5_flags", {28'd0, cpu_clr, done, overflow, timeout}, 32'h8);
        check("t5_ready", {31'd0, in_ready}, 32'd0);
        @(negedge Clk);
        Clr = 1'b1;
        pulse_start();
        send_byte(8'hAA, 1'b1, 0, 20, ok);
        wait_done("t5");
        check("t5_mem0", {24'd0, mem[0]}, 32'hAA);
        check("t5_reload_count", {22'd0, byte_count}, 32'd1);

        // 6: start during WAIT_BYTE is ignored
        pulse_start();
        send_byte(8'h11, 1'b0, 0, 20, ok);
        for (n = 0; n < 20 && !in_ready; n++) @(negedge Clk);
        pulse_start();
        check("t6_count", {22'd0, byte_count}, 32'd1);
        check("t6_addr", {23'd0, ram_addr}, 32'd1);
        check("t6_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h22, 1'b1, 0, 20, ok);
        wait_done("t6");
        check("t6_csum", {24'd0, checksum}, 32'h33);
        check("t6_mem1", {24'd0, mem[1]}, 32'h22);

        // 7: last byte exactly at address 511 -> no overflow
        pulse_start();
        nfail = 0;
        for (int i = 0; i < 512; i++) begin
            send_byte(8'h01, (i == 511), 0, 20, ok);
            if (!ok) nfail++;
        end
        check("t7_accept", nfail, 0);
        wait_done("t7");
        check("t7_overflow", {31'd0, overflow}, 32'd0);
        check("t7_cpu_clr", {31'd0, cpu_clr}, 32'd0);
        check("t7_count", {22'd0, byte_count}, 32'd512);
        check("t7_csum", {24'd0, checksum}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
